// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types for the serial/parallel converter pair
package serial_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } shift_direction_t;

endpackage

// File: rtl/serial_to_parallel_converter_if.sv
// rtl/serial_to_parallel_converter_if.sv - serial-in / parallel-out handshake bundle
interface serial_to_parallel_converter_if
    import serial_pkg::*;
#(
    parameter int N = 4
);
    logic                   i_valid;
    logic                   i_bit;
    shift_direction_t       direction;
    logic                   o_ready;
    logic [N-1:0]           o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic [$clog2(N)-1:0]   o_count;
    logic                   o_overrun;

    // master drives bits in and consumes words; slave is the converter
    modport master (
        output i_valid, i_bit, direction, i_ready,
        input  o_ready, o_data, o_valid, o_count, o_overrun
    );

    modport slave (
        input  i_valid, i_bit, direction, i_ready,
        output o_ready, o_data, o_valid, o_count, o_overrun
    );

endinterface

// File: rtl/serial_to_parallel_converter.sv
// rtl/serial_to_parallel_converter.sv - shifts serial bits into N-bit words with an output holding register
module serial_to_parallel_converter
    import serial_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    serial_to_parallel_converter_if.slave      bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  q;
    logic [N-1:0]  q_next;
    logic [N-1:0]  data_r;
    logic          valid_r;
    logic [CW-1:0] count_r;
    logic          overrun_r;
    logic          ready;
    logic          accept;
    logic          complete;

    // Only the final bit of a word must wait for the holding register to drain.
    assign ready    = rst | ~((count_r == LAST) & valid_r & ~bus.i_ready);
    assign accept   = bus.i_valid & ready & ~rst;
    assign complete = accept & (count_r == LAST);

    always_comb begin
        q_next = q;
        if (bus.direction == MSB_FIRST) begin
            q_next = {q[N-2:0], bus.i_bit};
        end else begin
            q_next = {bus.i_bit, q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (accept) begin
                q       <= q_next;
                count_r <= complete ? '0 : count_r + CW'(1);
            end
            // A completing word replaces one being consumed in the same cycle.
            if (complete) begin
                data_r  <= q_next;
                valid_r <= 1'b1;
            end else if (valid_r && bus.i_ready) begin
                valid_r <= 1'b0;
            end
            if (bus.i_valid && !ready) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_data    = data_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_count   = count_r;
    assign bus.o_overrun = overrun_r;

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// tb/tb_serial_to_parallel_converter.sv - scoreboard bench for serial_to_parallel_converter
module tb_serial_to_parallel_converter;
    import serial_pkg::*;

    logic clk = 1'b0;
    logic rst;

    serial_to_parallel_converter_if #(.N(4)) s ();

    serial_to_parallel_converter #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed word is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && s.o_valid && s.i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL word_unexpected: got %0h expected none", s.o_data);
            end else begin
                check("word", int'(s.o_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b);
        s.i_valid = v;
        s.i_bit   = b;
        cycle();
        s.i_valid = 1'b0;
    endtask

    logic [3:0] bits;

    initial begin
        rst         = 1'b1;
        s.i_valid   = 1'b0;
        s.i_bit     = 1'b0;
        s.i_ready   = 1'b1;
        s.direction = MSB_FIRST;
        cycle();
        s.i_valid = 1'b1;
        cycle();
        s.i_valid = 1'b0;
        check("rst_o_valid", int'(s.o_valid), 0);
        check("rst_o_data", int'(s.o_data), 0);
        check("rst_o_count", int'(s.o_count), 0);
        check("rst_o_overrun", int'(s.o_overrun), 0);
        check("rst_o_ready", int'(s.o_ready), 1);
        rst = 1'b0;

        // MSB first, back-to-back bits 1,0,1,1
        exp_q.push_back(4'b1011);
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i]);
        check("msb_valid_after_last", int'(s.o_valid), 1);
        check("msb_data", int'(s.o_data), 4'b1011);
        drive(1'b0, 1'b0);
        check("msb_valid_one_cycle", int'(s.o_valid), 0);

        // LSB first, same bits, count steps 0,1,2,3,0
        s.direction = LSB_FIRST;
        exp_q.push_back(4'b1101);
        check("lsb_count_0", int'(s.o_count), 0);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            check("lsb_count_step", int'(s.o_count), (4 - i) % 4);
        end
        check("lsb_data", int'(s.o_data), 4'b1101);
        drive(1'b0, 1'b0);

        // Stall: word A held, three more bits accepted, then o_ready drops
        s.direction = MSB_FIRST;
        s.i_ready   = 1'b0;
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h6);
        bits = 4'hA;
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i]);
        check("stall_valid", int'(s.o_valid), 1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("stall_count", int'(s.o_count), 3);
        check("stall_ready_low", int'(s.o_ready), 0);
        check("stall_data_held", int'(s.o_data), 4'hA);
        check("stall_no_overrun_yet", int'(s.o_overrun), 0);

        // Overrun: offered bit is dropped
        drive(1'b1, 1'b1);
        check("ovr_flag", int'(s.o_overrun), 1);
        check("ovr_count_held", int'(s.o_count), 3);
        check("ovr_data_held", int'(s.o_data), 4'hA);
        check("ovr_valid_held", int'(s.o_valid), 1);

        // Raise i_ready with the 4th bit presented: accepted same cycle
        s.i_ready = 1'b1;
        #1;
        check("release_ready_comb", int'(s.o_ready), 1);
        drive(1'b1, 1'b0);
        check("release_valid", int'(s.o_valid), 1);
        check("release_data", int'(s.o_data), 4'h6);
        drive(1'b0, 1'b0);
        check("ovr_sticky", int'(s.o_overrun), 1);
        check("release_valid_clear", int'(s.o_valid), 0);

        // Reset mid-word
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("pre_rst_count", int'(s.o_count), 2);
        rst = 1'b1;
        s.i_valid = 1'b1;
        #1;
        check("rst_ready_high", int'(s.o_ready), 1);
        cycle();
        s.i_valid = 1'b0;
        rst = 1'b0;
        check("midrst_count", int'(s.o_count), 0);
        check("midrst_valid", int'(s.o_valid), 0);
        check("midrst_data", int'(s.o_data), 0);
        check("midrst_overrun", int'(s.o_overrun), 0);
        exp_q.push_back(4'b0110);
        bits = 4'b0110;
        for (int i = 3; i >= 0; i--) drive(1'b1, bits[i]);
        check("post_rst_data", int'(s.o_data), 4'b0110);
        drive(1'b0, 1'b0);

        // Gaps of three idle cycles between bits
        exp_q.push_back(4'b1101);
        bits = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, bits[i]);
            if (i > 0) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'b0);
                    check("gap_count", int'(s.o_count), 4 - i);
                end
            end
        end
        check("gap_data", int'(s.o_data), 4'b1101);

        repeat (3) drive(1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
